uart_tx_buffered: RTL and testbench

FPGA-side UART transmit path: accepts bytes from the CPU over a ready/valid interface and serialises them onto serial_out as 8N1 frames. A small FIFO decouples CPU stores from the slow line rate, so echo and print loops can issue bursts without stalling per byte. It drives the line that the host bench samples at mid-bit: start=0, 8 data bits LSB-first, stop=1.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_fifo.sv | 52 +++++
 rtl/uart_tx_buffered.sv | 109 ++++++++++
 tb/tb_uart_tx_buffered.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants, transmit engine state encoding and baud divisor helper.
package uart_pkg;

    localparam int UART_FRAME_BITS = 10;
    localparam int UART_DATA_BITS  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // Truncating divide: the bit period rounds down to whole clock cycles.
    function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO; the occupancy count separates full from empty so pointers wrap freely.
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: FIFO in front of a start/data/stop shift engine.
// States: IDLE line high, wait for data | START start bit | DATA 8 bits LSB-first | STOP stop bit, chains to START if queued
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    data_in,
    input  logic                          data_in_valid,
    output logic                          data_in_ready,
    output logic                          serial_out,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int CNT_W            = $clog2(SYMBOL_EDGE_TIME);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SYMBOL_EDGE_TIME - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             serial_q, serial_d;
    logic             push, pop, bit_done;
    logic             fifo_full, fifo_empty;
    logic [7:0]       fifo_rd_data;

    assign data_in_ready = !fifo_full;
    assign push          = data_in_valid && data_in_ready;
    assign bit_done      = (baud_cnt_q == '0);
    assign serial_out    = serial_q;
    assign tx_busy       = (state_q != ST_IDLE) || (fifo_count != '0);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (data_in),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            serial_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            serial_q   <= serial_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!fifo_empty) state_d = ST_START;
            ST_START: if (bit_done) state_d = ST_DATA;
            ST_DATA:  if (bit_done && (bit_idx_q == 3'(UART_DATA_BITS - 1))) state_d = ST_STOP;
            ST_STOP:  if (bit_done) state_d = fifo_empty ? ST_IDLE : ST_START;
            default:  state_d = ST_IDLE;
        endcase
    end

    // serial_d is registered, so the line trails the state by one cycle uniformly.
    always_comb begin
        pop        = 1'b0;
        serial_d   = 1'b1;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        if (state_q != ST_IDLE) begin
            baud_cnt_d = bit_done ? CNT_RELOAD : baud_cnt_q - CNT_W'(1);
        end
        case (state_q)
            ST_IDLE:  pop = !fifo_empty;
            ST_START: begin
                serial_d = 1'b0;
                if (bit_done) bit_idx_d = '0;
            end
            ST_DATA:  begin
                serial_d = shift_q[bit_idx_q];
                if (bit_done) bit_idx_d = bit_idx_q + 3'd1;
            end
            ST_STOP:  pop = bit_done && !fifo_empty;
            default:  pop = 1'b0;
        endcase
        if (pop) begin
            shift_d    = fifo_rd_data;
            baud_cnt_d = CNT_RELOAD;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench: default-rate DUT plus a 125 MHz DUT, line decoded at mid-bit.
module tb_uart_tx_buffered;

    localparam int P_A = 434;
    localparam int P_B = 1085;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_a = '0, data_b = '0;
    logic       valid_a = 1'b0, valid_b = 1'b0;
    logic       ready_a, ready_b, ser_a, ser_b, busy_a, busy_b;
    logic [3:0] count_a, count_b;

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;
    logic full_seen = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_buffered dut_a (
        .clk(clk), .rst(rst), .data_in(data_a), .data_in_valid(valid_a),
        .data_in_ready(ready_a), .serial_out(ser_a), .tx_busy(busy_a), .fifo_count(count_a)
    );

    uart_tx_buffered #(.CLOCK_FREQ(125_000_000), .BAUD_RATE(115_200), .FIFO_DEPTH(8)) dut_b (
        .clk(clk), .rst(rst), .data_in(data_b), .data_in_valid(valid_b),
        .data_in_ready(ready_b), .serial_out(ser_b), .tx_busy(busy_b), .fifo_count(count_b)
    );

    typedef struct { logic [9:0] bits; int fall; } frame_t;
    typedef struct { logic [7:0] data; logic [9:0] frame; } vec_t;

    frame_t rxq_a[$];
    frame_t rxq_b[$];

    // Line monitor: frame bit i is sampled P/2 + i*P cycles after the first low sample.
    logic       m_act[2];
    int         m_cnt[2], m_bit[2], m_fall[2];
    logic [9:0] m_fr[2];
    initial begin
        int per [2];
        per[0] = P_A;
        per[1] = P_B;
        for (int d = 0; d < 2; d++) m_act[d] = 1'b0;
        forever begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                logic s;
                s = (d == 0) ? ser_a : ser_b;
                if (rst) begin
                    m_act[d] = 1'b0;
                end else begin
                    if (!m_act[d] && s == 1'b0) begin
                        m_act[d] = 1'b1; m_cnt[d] = 0; m_bit[d] = 0; m_fall[d] = cyc;
                    end
                    if (m_act[d]) begin
                        if (m_cnt[d] == per[d] / 2 + m_bit[d] * per[d]) begin
                            m_fr[d][m_bit[d]] = s;
                            m_bit[d]++;
                            if (m_bit[d] == 10) begin
                                m_act[d] = 1'b0;
                                if (d == 0) rxq_a.push_back('{bits: m_fr[0], fall: m_fall[0]});
                                else        rxq_b.push_back('{bits: m_fr[1], fall: m_fall[1]});
                            end
                        end
                        m_cnt[d]++;
                    end
                end
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time exhausted at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic push_byte(input int d, input logic [7:0] b, output int acc);
        logic rdy;
        acc = -1;
        if (d == 0) begin data_a = b; valid_a = 1'b1; end
        else        begin data_b = b; valid_b = 1'b1; end
        for (int k = 0; k < 20000 && acc < 0; k++) begin
            rdy = (d == 0) ? ready_a : ready_b;
            if (!rdy && d == 0 && !full_seen) begin
                full_seen = 1'b1;
                check("count_when_not_ready", 32'(count_a), 32'd8);
            end
            @(posedge clk); #1;
            if (rdy) acc = cyc;
        end
        valid_a = 1'b0;
        valid_b = 1'b0;
        if (acc < 0) begin
            n_vec++; n_miss++;
            $display("FAIL accept_timeout: byte 0x%0h never accepted, expected accept", b);
            acc = cyc;
        end
    endtask

    task automatic wait_frames(input int d, input int n, input int budget);
        int k = 0;
        while (((d == 0) ? rxq_a.size() : rxq_b.size()) < n && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        if (((d == 0) ? rxq_a.size() : rxq_b.size()) < n) begin
            n_vec++; n_miss++;
            $display("FAIL frame_timeout: dut %0d got %0d frames, expected %0d", d,
                     (d == 0) ? rxq_a.size() : rxq_b.size(), n);
        end
    endtask

    task automatic wait_idle_a();
        int k = 0;
        while (busy_a && k < 6000) begin
            @(posedge clk); #1;
            k++;
        end
        check("idle_reached", 32'(busy_a), 32'd0);
    endtask

    initial begin
        vec_t   vecs[4];
        frame_t fr;
        int     acc, f0;
        int     accs[10];
        logic   low_seen;

        vecs[0] = '{data: 8'h61, frame: 10'b1_0110_0001_0};
        vecs[1] = '{data: 8'hA5, frame: 10'b1_1010_0101_0};
        vecs[2] = '{data: 8'hFF, frame: 10'b1_1111_1111_0};
        vecs[3] = '{data: 8'h00, frame: 10'b1_0000_0000_0};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_serial_out", 32'(ser_a), 32'd1);
        check("rst_ready", 32'(ready_a), 32'd1);
        check("rst_tx_busy", 32'(busy_a), 32'd0);
        check("rst_fifo_count", 32'(count_a), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            push_byte(0, vecs[i].data, acc);
            f0 = acc + 2;
            if (i == 0) begin
                wait_until(acc + 1);
                check("line_high_1st_edge", 32'(ser_a), 32'd1);
                wait_until(f0);
                check("line_low_2nd_edge", 32'(ser_a), 32'd0);
                wait_until(f0 + P_A - 1);
                check("start_last_cycle", 32'(ser_a), 32'd0);
                wait_until(f0 + P_A);
                check("bit0_first_cycle", 32'(ser_a), 32'd1);
                wait_until(f0 + 9 * P_A + P_A / 2);
                check("busy_in_stop", 32'(busy_a), 32'd1);
                wait_until(f0 + 10 * P_A);
                check("busy_after_stop", 32'(busy_a), 32'd0);
                check("line_idle_after_stop", 32'(ser_a), 32'd1);
            end
            wait_frames(0, 1, 6000);
            if (rxq_a.size() > 0) begin
                fr = rxq_a.pop_front();
                check($sformatf("vec%0d_frame", i), 32'(fr.bits), 32'(vecs[i].frame));
                check($sformatf("vec%0d_latency", i), 32'(fr.fall), 32'(f0));
            end
            wait_idle_a();
        end

        // Burst of ten with valid held: fills the FIFO while the first frame shifts out.
        full_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            push_byte(0, 8'h61 + 8'(i), accs[i]);
            if (i == 1) check("push_pop_count", 32'(count_a), 32'd1);
            if (i == 8) begin
                check("full_count", 32'(count_a), 32'd8);
                check("full_ready", 32'(ready_a), 32'd0);
            end
        end
        check("full_seen", 32'(full_seen), 32'd1);
        check("accept_after_pop", 32'(accs[9]), 32'(accs[0] + 4342));
        wait_frames(0, 10, 50000);
        repeat (500) @(posedge clk);
        #1;
        check("burst_frame_count", 32'(rxq_a.size()), 32'd10);
        check("burst_idle", 32'(busy_a), 32'd0);
        if (rxq_a.size() == 10) begin
            f0 = rxq_a[0].fall;
            check("burst_first_latency", 32'(f0), 32'(accs[0] + 2));
            for (int k = 0; k < 10; k++) begin
                check($sformatf("burst%0d_frame", k), 32'(rxq_a[k].bits),
                      32'({1'b1, 8'h61 + 8'(k), 1'b0}));
                check($sformatf("burst%0d_start", k), 32'(rxq_a[k].fall), 32'(f0 + 4340 * k));
            end
            check("burst_total", 32'(rxq_a[9].fall + 4340 - f0), 32'd43400);
        end
        rxq_a.delete();

        // Reset in the middle of the data bits of 0x55 with three bytes queued.
        push_byte(0, 8'h55, acc);
        f0 = acc + 2;
        push_byte(0, 8'h11, accs[0]);
        push_byte(0, 8'h22, accs[0]);
        push_byte(0, 8'h33, accs[0]);
        check("queued_three", 32'(count_a), 32'd3);
        wait_until(f0 + 3 * P_A + 100);
        rst = 1'b1;
        data_a = 8'hEE;
        valid_a = 1'b1;
        @(posedge clk); #1;
        check("midrst_serial", 32'(ser_a), 32'd1);
        check("midrst_count", 32'(count_a), 32'd0);
        check("midrst_ready", 32'(ready_a), 32'd1);
        check("midrst_busy", 32'(busy_a), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        valid_a = 1'b0;
        @(posedge clk); #1;
        check("valid_in_rst_ignored", 32'(count_a), 32'd0);
        low_seen = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            if (ser_a !== 1'b1) low_seen = 1'b1;
            @(posedge clk); #1;
        end
        check("line_high_after_rst", 32'(low_seen), 32'd0);
        check("no_frames_after_rst", 32'(rxq_a.size()), 32'd0);

        // 125 MHz instance: 1085-cycle bits.
        push_byte(1, 8'hA5, acc);
        f0 = acc + 2;
        wait_until(f0 + P_B - 1);
        check("b_start_last_cycle", 32'(ser_b), 32'd0);
        wait_until(f0 + P_B);
        check("b_bit0_first_cycle", 32'(ser_b), 32'd1);
        wait_frames(1, 1, 12000);
        if (rxq_b.size() > 0) begin
            fr = rxq_b.pop_front();
            check("b_frame_a5", 32'(fr.bits), 32'(10'b1_1010_0101_0));
            check("b_latency", 32'(fr.fall), 32'(f0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
